// File: rtl/playback_progress_ctrl.sv
// playback_progress_ctrl: play/pause/stop sequencer for one song's progress display.
// Runs a tick prescaler and an elapsed-tick counter, and derives the bar-fill pixel
// boundary and an 8-bit colour ramp without dividers.
// Optional feature macro: PROGRESS_LOOP_EN (loop the song forever instead of entering DONE).
module playback_progress_ctrl #(
    parameter int unsigned TICK_DIV        = 20000,
    parameter int unsigned SAMPLE_INTERVAL = 50,
    parameter int unsigned BAR_WIDTH       = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic [9:0]  duration,
    output logic [1:0]  state,
    output logic        busy,
    output logic        tick,
    output logic [19:0] elapsed,
    output logic [9:0]  bar_x,
    output logic [7:0]  ramp,
    output logic        done
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Accumulators hold a remainder below total plus at most one pending step.
    localparam int unsigned ACC_W   = 21;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [9:0]         BAR_MAX   = 10'(BAR_WIDTH);
    localparam logic [ACC_W-1:0]   BAR_STEP  = ACC_W'(BAR_WIDTH);
    localparam logic [ACC_W-1:0]   RAMP_STEP = ACC_W'(256);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [19:0]        total_q, total_d;
    logic [ACC_W-1:0]   bar_acc_q, bar_acc_d;
    logic [ACC_W-1:0]   ramp_acc_q, ramp_acc_d;
    logic [ACC_W-1:0]   total_ext;
    logic [1:0]         state_d;
    logic               busy_d, tick_d, done_d;
    logic [19:0]        elapsed_d;
    logic [9:0]         bar_x_d;
    logic [7:0]         ramp_d;

    assign total_ext = ACC_W'(total_q);

    // Next-state and next-value logic: stop > start > pause, completion overrides normalisation.
    always_comb begin
        state_d    = state;
        presc_d    = presc_q;
        total_d    = total_q;
        elapsed_d  = elapsed;
        bar_x_d    = bar_x;
        ramp_d     = ramp;
        bar_acc_d  = bar_acc_q;
        ramp_acc_d = ramp_acc_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            presc_d    = '0;
            total_d    = '0;
            elapsed_d  = '0;
            bar_x_d    = '0;
            ramp_d     = '0;
            bar_acc_d  = '0;
            ramp_acc_d = '0;
        end else if (start && (duration != 10'd0)) begin
            state_d    = ST_RUN;
            presc_d    = '0;
            total_d    = 20'(duration) * 20'(SAMPLE_INTERVAL);
            elapsed_d  = '0;
            bar_x_d    = '0;
            ramp_d     = '0;
            bar_acc_d  = '0;
            ramp_acc_d = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d    = '0;
                        tick_d     = 1'b1;
                        elapsed_d  = elapsed + 20'd1;
                        bar_acc_d  = bar_acc_q + BAR_STEP;
                        ramp_acc_d = ramp_acc_q + RAMP_STEP;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                        // One restoring subtraction per accumulator per cycle.
                        if (bar_acc_q >= total_ext) begin
                            bar_acc_d = bar_acc_q - total_ext;
                            if (bar_x < BAR_MAX) bar_x_d = bar_x + 10'd1;
                        end
                        if (ramp_acc_q >= total_ext) begin
                            ramp_acc_d = ramp_acc_q - total_ext;
                            if (ramp != 8'd255) ramp_d = ramp + 8'd1;
                        end
                    end
                    if (pause) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!pause) state_d = ST_RUN;
                end
                default: ;
            endcase

            // The cycle after the completing tick finalises the song.
            if (busy && tick && (elapsed == total_q)) begin
                done_d     = 1'b1;
                bar_acc_d  = '0;
                ramp_acc_d = '0;
`ifdef PROGRESS_LOOP_EN
                elapsed_d  = '0;
                bar_x_d    = '0;
                ramp_d     = '0;
`else
                state_d    = ST_DONE;
                presc_d    = '0;
                bar_x_d    = BAR_MAX;
                ramp_d     = 8'd255;
`endif
            end
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            elapsed    <= '0;
            bar_x      <= '0;
            ramp       <= '0;
            presc_q    <= '0;
            total_q    <= '0;
            bar_acc_q  <= '0;
            ramp_acc_q <= '0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            tick       <= tick_d;
            done       <= done_d;
            elapsed    <= elapsed_d;
            bar_x      <= bar_x_d;
            ramp       <= ramp_d;
            presc_q    <= presc_d;
            total_q    <= total_d;
            bar_acc_q  <= bar_acc_d;
            ramp_acc_q <= ramp_acc_d;
        end
    end

endmodule
